// File: rtl/mmio_fifo_pkg.sv
// Shared register map and STATUS field layout for the MMIO FIFO controller.
package mmio_fifo_pkg;

    localparam logic [15:0] ADDR_DATA   = 16'h0020;
    localparam logic [15:0] ADDR_STATUS = 16'h0022;
    localparam logic [15:0] ADDR_CTRL   = 16'h0024;
    localparam logic [15:0] ADDR_PEEK   = 16'h0026;

    localparam int unsigned STAT_CNT_W = 7;
    localparam int unsigned STAT_EMPTY = 8;
    localparam int unsigned STAT_FULL  = 9;
    localparam int unsigned STAT_OVF   = 10;
    localparam int unsigned STAT_UNF   = 11;

    localparam int unsigned CTRL_FLUSH = 0;
    localparam int unsigned CTRL_CLR   = 1;

    function automatic logic [63:0] pack_status(logic [STAT_CNT_W-1:0] cnt, logic empty,
                                                logic full, logic ovf, logic unf);
        logic [63:0] s;
        s = '0;
        s[STAT_CNT_W-1:0] = cnt;
        s[STAT_EMPTY]     = empty;
        s[STAT_FULL]      = full;
        s[STAT_OVF]       = ovf;
        s[STAT_UNF]       = unf;
        return s;
    endfunction

endpackage

// File: rtl/mmio_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module mmio_fifo_ram #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO-mapped FIFO with DATA/STATUS/CTRL registers and one-cycle registered read responses.
// Define MMIO_FIFO_PEEK_EN to decode the non-popping PEEK register.
module mmio_fifo_ctrl #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [15:0] wr_addr,
    input  logic [63:0] wr_data,
    input  logic        rd_valid,
    input  logic [15:0] rd_addr,
    input  logic [8:0]  rd_tid,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data,
    output logic        rsp_hit
);
    import mmio_fifo_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              empty, full, push_req, pop_req, push, pop, flush, clr_sticky;
    logic [DATA_W-1:0] head;
    logic [63:0]       head_ext, status_word, rsp_data_d;
    logic              rsp_hit_d;

    mmio_fifo_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_q),
        .wdata (wr_data[DATA_W-1:0]),
        .raddr (rptr_q),
        .rdata (head)
    );

    always_comb begin
        empty      = (cnt_q == '0);
        full       = (cnt_q == CNT_W'(DEPTH));
        push_req   = wr_valid && (wr_addr == ADDR_DATA);
        pop_req    = rd_valid && (rd_addr == ADDR_DATA);
        flush      = wr_valid && (wr_addr == ADDR_CTRL) && wr_data[CTRL_FLUSH];
        clr_sticky = wr_valid && (wr_addr == ADDR_CTRL) && wr_data[CTRL_CLR];
        pop        = pop_req && !empty;
        // A pop frees the slot, so a push into a full FIFO is still accepted.
        push       = push_req && (!full || pop);

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
            else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
        end

        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clr_sticky) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (push_req && full && !pop) ovf_d = 1'b1;
        if (pop_req && empty)         unf_d = 1'b1;
    end

    always_comb begin
        head_ext = '0;
        head_ext[DATA_W-1:0] = head;
        status_word = pack_status(STAT_CNT_W'(cnt_q), empty, full, ovf_q, unf_q);

        rsp_data_d = '0;
        rsp_hit_d  = 1'b0;
        case (rd_addr)
            ADDR_DATA: begin
                rsp_hit_d  = 1'b1;
                rsp_data_d = empty ? '0 : head_ext;
            end
            ADDR_STATUS: begin
                rsp_hit_d  = 1'b1;
                rsp_data_d = status_word;
            end
            ADDR_CTRL: begin
                rsp_hit_d = 1'b1;
            end
`ifdef MMIO_FIFO_PEEK_EN
            ADDR_PEEK: begin
                rsp_hit_d  = 1'b1;
                rsp_data_d = empty ? '0 : head_ext;
            end
`endif
            default: begin
                rsp_hit_d  = 1'b0;
                rsp_data_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
            rsp_hit   <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            rsp_valid <= rd_valid;
            rsp_data  <= rd_valid ? rsp_data_d : '0;
            rsp_hit   <= rd_valid && rsp_hit_d;
            if (rd_valid) rsp_tid <= rd_tid;
        end
    end

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Directed self-checking bench for mmio_fifo_ctrl (DEPTH=8, DATA_W=64).
module tb_mmio_fifo_ctrl;

    localparam logic [15:0] A_DATA = 16'h0020;
    localparam logic [15:0] A_STAT = 16'h0022;
    localparam logic [15:0] A_CTRL = 16'h0024;
    localparam logic [15:0] A_PEEK = 16'h0026;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        rd_valid = 1'b0;
    logic [15:0] rd_addr = '0;
    logic [8:0]  rd_tid = '0;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        rsp_hit;

    int errors = 0;
    int checks = 0;

    logic [63:0] r_d;
    logic        r_h, r_v;
    logic [8:0]  r_t;

    mmio_fifo_ctrl #(
        .DEPTH  (8),
        .DATA_W (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_tid    (rd_tid),
        .rsp_valid (rsp_valid),
        .rsp_tid   (rsp_tid),
        .rsp_data  (rsp_data),
        .rsp_hit   (rsp_hit)
    );

    always #5 clk = ~clk;

    // One-cycle transaction driven on a falling edge; response sampled on the next falling edge.
    task automatic xact(input logic w, input logic [15:0] wa, input logic [63:0] wd,
                        input logic r, input logic [15:0] ra, input logic [8:0] tid);
        @(negedge clk);
        wr_valid = w; wr_addr = wa; wr_data = wd;
        rd_valid = r; rd_addr = ra; rd_tid = tid;
        @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b0;
        r_d = rsp_data; r_h = rsp_hit; r_v = rsp_valid; r_t = rsp_tid;
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        xact(1'b1, a, d, 1'b0, '0, '0);
    endtask

    task automatic rd(input logic [15:0] a, input logic [8:0] tid);
        xact(1'b0, '0, '0, 1'b1, a, tid);
    endtask

    task automatic test_reset;
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_hit !== 1'b0 || rsp_tid !== '0)
            begin errors++; $display("FAIL reset_outputs: got v=%b d=%h h=%b t=%h want all 0",
                                     rsp_valid, rsp_data, rsp_hit, rsp_tid); end
        // Read captured while reset is still high must not be answered.
        @(negedge clk); rd_valid = 1'b1; rd_addr = A_STAT; rd_tid = 9'h1AB;
        @(negedge clk); rst = 1'b0; rd_valid = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0)
            begin errors++; $display("FAIL reset_read_discard: got v=%b want 0", rsp_valid); end
        rd(A_STAT, 9'h05);
        checks++; if (r_v !== 1'b1 || r_h !== 1'b1 || r_t !== 9'h05 || r_d !== 64'h100)
            begin errors++; $display("FAIL reset_status: got v=%b h=%b t=%h d=%h want 1 1 005 100",
                                     r_v, r_h, r_t, r_d); end
    endtask

    task automatic test_basic;
        logic [63:0] exp [3];
        exp[0] = 64'h11; exp[1] = 64'h22; exp[2] = 64'h33;
        for (int i = 0; i < 3; i++) wr(A_DATA, exp[i]);
        for (int i = 0; i < 3; i++) begin
            rd(A_DATA, 9'(i + 1));
            checks++; if (r_v !== 1'b1 || r_d !== exp[i] || r_t !== 9'(i + 1) || r_h !== 1'b1)
                begin errors++; $display("FAIL basic_pop%0d: got v=%b d=%h t=%h h=%b want d=%h t=%h",
                                         i, r_v, r_d, r_t, r_h, exp[i], 9'(i + 1)); end
        end
        rd(A_STAT, 9'h0);
        checks++; if (r_d !== 64'h100)
            begin errors++; $display("FAIL basic_status: got %h want 100", r_d); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 9; i++) wr(A_DATA, 64'h100 + 64'(i));
        rd(A_STAT, 9'h0);
        checks++; if (r_d !== 64'h608)
            begin errors++; $display("FAIL ovf_status: got %h want 608", r_d); end
        for (int i = 0; i < 8; i++) begin
            rd(A_DATA, 9'h0);
            checks++; if (r_d !== 64'h100 + 64'(i))
                begin errors++; $display("FAIL ovf_pop%0d: got %h want %h", i, r_d, 64'h100 + 64'(i)); end
        end
        rd(A_STAT, 9'h0);
        checks++; if (r_d !== 64'h500)
            begin errors++; $display("FAIL ovf_drained_status: got %h want 500", r_d); end
        wr(A_CTRL, 64'h2);
    endtask

    task automatic test_underflow;
        rd(A_DATA, 9'h33);
        checks++; if (r_d !== '0 || r_h !== 1'b1 || r_t !== 9'h33)
            begin errors++; $display("FAIL unf_data: got d=%h h=%b t=%h want 0 1 033", r_d, r_h, r_t); end
        rd(A_STAT, 9'h0);
        checks++; if (r_d !== 64'h900)
            begin errors++; $display("FAIL unf_status: got %h want 900", r_d); end
        wr(A_CTRL, 64'h2);
        rd(A_STAT, 9'h0);
        checks++; if (r_d !== 64'h100)
            begin errors++; $display("FAIL unf_cleared: got %h want 100", r_d); end
        // Clear and a new underflow in the same cycle: set wins.
        xact(1'b1, A_CTRL, 64'h2, 1'b1, A_DATA, 9'h0);
        rd(A_STAT, 9'h0);
        checks++; if (r_d !== 64'h900)
            begin errors++; $display("FAIL unf_set_priority: got %h want 900", r_d); end
        wr(A_CTRL, 64'h2);
    endtask

    task automatic test_simul_full;
        logic [63:0] q [$];
        for (int i = 0; i < 8; i++) wr(A_DATA, 64'h200 + 64'(i));
        xact(1'b1, A_DATA, 64'hAA, 1'b1, A_DATA, 9'h7);
        checks++; if (r_d !== 64'h200)
            begin errors++; $display("FAIL full_pp_data: got %h want 200", r_d); end
        rd(A_STAT, 9'h0);
        checks++; if (r_d !== 64'h208)
            begin errors++; $display("FAIL full_pp_status: got %h want 208", r_d); end
        for (int i = 1; i < 9; i++) begin
            rd(A_DATA, 9'h0);
            checks++; if (r_d !== ((i == 8) ? 64'hAA : 64'h200 + 64'(i)))
                begin errors++; $display("FAIL full_drain%0d: got %h", i, r_d); end
        end
        for (int i = 0; i < 3; i++) begin
            wr(A_DATA, 64'h300 + 64'(i)); q.push_back(64'h300 + 64'(i));
        end
        for (int i = 0; i < 20; i++) begin
            xact(1'b1, A_DATA, 64'h400 + 64'(i), 1'b1, A_DATA, 9'(i));
            q.push_back(64'h400 + 64'(i));
            checks++; if (r_d !== q[0])
                begin errors++; $display("FAIL wrap%0d: got %h want %h", i, r_d, q[0]); end
            void'(q.pop_front());
        end
        for (int i = 0; i < 3; i++) begin
            rd(A_DATA, 9'h0);
            checks++; if (r_d !== q[0])
                begin errors++; $display("FAIL wrap_drain%0d: got %h want %h", i, r_d, q[0]); end
            void'(q.pop_front());
        end
        rd(A_STAT, 9'h0);
        checks++; if (r_d !== 64'h100)
            begin errors++; $display("FAIL wrap_status: got %h want 100", r_d); end
    endtask

    task automatic test_simul_empty;
        xact(1'b1, A_DATA, 64'h77, 1'b1, A_DATA, 9'h9);
        checks++; if (r_d !== '0 || r_h !== 1'b1)
            begin errors++; $display("FAIL empty_pp_data: got d=%h h=%b want 0 1", r_d, r_h); end
        rd(A_STAT, 9'h0);
        checks++; if (r_d !== 64'h801)
            begin errors++; $display("FAIL empty_pp_status: got %h want 801", r_d); end
        rd(A_DATA, 9'h0);
        checks++; if (r_d !== 64'h77)
            begin errors++; $display("FAIL empty_pp_pop: got %h want 77", r_d); end
        wr(A_CTRL, 64'h2);
    endtask

    task automatic test_flush;
        for (int i = 0; i < 4; i++) wr(A_DATA, 64'h500 + 64'(i));
        wr(A_CTRL, 64'h1);
        rd(A_STAT, 9'h0);
        checks++; if (r_d !== 64'h100)
            begin errors++; $display("FAIL flush_status: got %h want 100", r_d); end
        rd(A_DATA, 9'h0);
        checks++; if (r_d !== '0)
            begin errors++; $display("FAIL flush_pop: got %h want 0", r_d); end
        rd(A_STAT, 9'h0);
        checks++; if (r_d !== 64'h900)
            begin errors++; $display("FAIL flush_unf: got %h want 900", r_d); end
        wr(A_CTRL, 64'h2);
        wr(A_DATA, 64'h31);
        wr(A_DATA, 64'h32);
        xact(1'b1, A_CTRL, 64'h1, 1'b1, A_DATA, 9'h0);
        checks++; if (r_d !== 64'h31)
            begin errors++; $display("FAIL flush_pop_head: got %h want 31", r_d); end
        rd(A_STAT, 9'h0);
        checks++; if (r_d !== 64'h100)
            begin errors++; $display("FAIL flush_pop_status: got %h want 100", r_d); end
    endtask

    task automatic test_status_pre;
        xact(1'b1, A_DATA, 64'h99, 1'b1, A_STAT, 9'h0);
        checks++; if (r_d !== 64'h100)
            begin errors++; $display("FAIL status_pre: got %h want 100", r_d); end
        rd(A_STAT, 9'h0);
        checks++; if (r_d !== 64'h001)
            begin errors++; $display("FAIL status_post: got %h want 001", r_d); end
        rd(A_DATA, 9'h0);
        checks++; if (r_d !== 64'h99)
            begin errors++; $display("FAIL status_pop: got %h want 99", r_d); end
    endtask

    task automatic test_decode;
        rd(16'h0030, 9'h1FF);
        checks++; if (r_d !== '0 || r_h !== 1'b0 || r_v !== 1'b1 || r_t !== 9'h1FF)
            begin errors++; $display("FAIL undecoded: got d=%h h=%b v=%b t=%h want 0 0 1 1ff",
                                     r_d, r_h, r_v, r_t); end
        wr(A_DATA, 64'hDEAD);
        rd(A_CTRL, 9'h0);
        checks++; if (r_d !== '0 || r_h !== 1'b1)
            begin errors++; $display("FAIL ctrl_read: got d=%h h=%b want 0 1", r_d, r_h); end
        rd(A_DATA, 9'h0);
        checks++; if (r_d !== 64'hDEAD)
            begin errors++; $display("FAIL ctrl_read_nopop: got %h want dead", r_d); end
    endtask

    task automatic test_peek;
        logic [63:0] exp_d;
        logic        exp_h;
`ifdef MMIO_FIFO_PEEK_EN
        exp_d = 64'h55; exp_h = 1'b1;
`else
        exp_d = 64'h0;  exp_h = 1'b0;
`endif
        wr(A_DATA, 64'h55);
        for (int i = 0; i < 2; i++) begin
            rd(A_PEEK, 9'(i));
            checks++; if (r_d !== exp_d || r_h !== exp_h)
                begin errors++; $display("FAIL peek%0d: got d=%h h=%b want d=%h h=%b",
                                         i, r_d, r_h, exp_d, exp_h); end
        end
        rd(A_STAT, 9'h0);
        checks++; if (r_d !== 64'h001)
            begin errors++; $display("FAIL peek_status: got %h want 001", r_d); end
        rd(A_DATA, 9'h0);
    endtask

    task automatic test_back_to_back;
        wr(A_DATA, 64'hA1);
        wr(A_DATA, 64'hA2);
        @(negedge clk); rd_valid = 1'b1; rd_addr = A_DATA; rd_tid = 9'h15;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'hA1 || rsp_tid !== 9'h15)
            begin errors++; $display("FAIL b2b_first: got v=%b d=%h t=%h want 1 a1 015",
                                     rsp_valid, rsp_data, rsp_tid); end
        rd_tid = 9'h16;
        @(negedge clk); rd_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'hA2 || rsp_tid !== 9'h16)
            begin errors++; $display("FAIL b2b_second: got v=%b d=%h t=%h want 1 a2 016",
                                     rsp_valid, rsp_data, rsp_tid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0)
            begin errors++; $display("FAIL b2b_idle: got v=%b want 0", rsp_valid); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_underflow();
        test_simul_full();
        test_simul_empty();
        test_flush();
        test_status_pre();
        test_decode();
        test_peek();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
